bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 11 +
 rtl/bit_serializer_if.sv | 36 +++
 rtl/bit_serializer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// rtl/bit_serializer_pkg.sv - shared state encoding and default word width for the bit serializer
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bit_serializer_if.sv
// rtl/bit_serializer_if.sv - parallel word handshake and serial bit stream bundle
interface bit_serializer_if
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             in_bit;
    logic             bit_valid;
    logic             frame_start;
    logic             busy;

    // master: word producer / stream consumer; slave: the serializer itself
    modport master (
        output data_in,
        output data_valid,
        input  data_ready,
        input  in_bit,
        input  bit_valid,
        input  frame_start,
        input  busy
    );

    modport slave (
        input  data_in,
        input  data_valid,
        output data_ready,
        output in_bit,
        output bit_valid,
        output frame_start,
        output busy
    );

endinterface

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial converter with a one-word hold register for gapless streaming
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    bit_serializer_if.slave  bus
);

    localparam int              CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_e           state_q,       state_d;
    logic [CW-1:0]    cnt_q,         cnt_d;
    logic [WIDTH-1:0] shreg_q,       shreg_d;
    logic [WIDTH-1:0] hold_q,        hold_d;
    logic             hold_full_q,   hold_full_d;
    logic             in_bit_q,      in_bit_d;
    logic             bit_valid_q,   bit_valid_d;
    logic             frame_start_q, frame_start_d;

    logic             data_ready;
    logic             accept;
    logic             load;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] next_shreg;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign data_ready = reset & ~hold_full_q;
    assign accept     = bus.data_valid & data_ready;
    assign next_shreg = advance(shreg_q);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        in_bit_d      = in_bit_q;
        bit_valid_d   = bit_valid_q;
        frame_start_d = 1'b0;
        load          = 1'b0;
        load_word     = bus.data_in;

        case (state_q)
            IDLE: begin
                load = accept;
            end
            SHIFT: begin
                if (cnt_q != LAST) begin
                    cnt_d    = cnt_q + CW'(1);
                    shreg_d  = next_shreg;
                    in_bit_d = first_bit(next_shreg);
                    if (accept) begin
                        hold_d      = bus.data_in;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    // a held word always wins over data_in: ready is low while hold is full
                    load        = 1'b1;
                    load_word   = hold_q;
                    hold_full_d = 1'b0;
                end else if (accept) begin
                    load = 1'b1;
                end else begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    shreg_d     = '0;
                    in_bit_d    = 1'b0;
                    bit_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d       = SHIFT;
            cnt_d         = '0;
            shreg_d       = load_word;
            in_bit_d      = first_bit(load_word);
            bit_valid_d   = 1'b1;
            frame_start_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            in_bit_q      <= 1'b0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            in_bit_q      <= in_bit_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.data_ready  = data_ready;
    assign bus.in_bit      = in_bit_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = (state_q == SHIFT) | hold_full_q;

endmodule
